// File: rtl/alu_pkg.sv
// Shared types and constants for the 12-bit datapath ALU.
// Optional zero flag is enabled by defining ALU_ZERO_FLAG_EN.
package alu_pkg;

   localparam int WIDTH_DEFAULT = 12;
   localparam int ROT_AMT_W     = 4;

   typedef enum logic [2:0] {
      ADD   = 3'b000,
      SUB   = 3'b001,
      ROT_L = 3'b010,
      ROT_R = 3'b011,
      XOR   = 3'b100,
      AND   = 3'b101,
      OR    = 3'b110,
      NOT   = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_rotator.sv
// Combinational circular rotator; the amount is reduced modulo WIDTH first.
// dir = 0 rotates left, dir = 1 rotates right.
module alu_rotator
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0]     value,
   input  logic [ROT_AMT_W-1:0] amount,
   input  logic                 dir,
   output logic [WIDTH-1:0]     rotated
);

   int unsigned          amt_mod;
   logic [2*WIDTH-1:0]   dbl;
   logic [2*WIDTH-1:0]   shifted;

   // Rotating a doubled copy keeps the wrapped-around bits in the window we keep.
   always_comb begin
      amt_mod = int'(amount) % WIDTH;
      dbl     = {value, value};
      shifted = '0;
      rotated = '0;
      if (dir) begin
         shifted = dbl >> amt_mod;
         rotated = shifted[WIDTH-1:0];
      end else begin
         shifted = dbl << amt_mod;
         rotated = shifted[2*WIDTH-1:WIDTH];
      end
   end

endmodule

// File: rtl/alu.sv
// Registered 12-bit ALU: add/sub with carry, rotates, logic ops and flags.
// Define ALU_ZERO_FLAG_EN to add the registered zero_out flag.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   input  logic [2:0]       func_code,
   output logic [WIDTH-1:0] a_out,
   output logic             carry_out,
   output logic             equ_out,
   output logic             overflow_out
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic             zero_out
`endif
);

   alu_op_e          op;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] rot_value;

   logic [WIDTH-1:0] res_d, res_q;
   logic             carry_d, carry_q;
   logic             equ_d, equ_q;
   logic             ovf_d, ovf_q;

   alu_rotator #(
      .WIDTH (WIDTH)
   ) u_rotator (
      .value   (a_in),
      .amount  (b_in[ROT_AMT_W-1:0]),
      .dir     (op == ROT_R),
      .rotated (rot_value)
   );

   always_comb begin
      op       = alu_op_e'(func_code);
      add_sum  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
      sub_diff = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, carry_in};
      res_d    = '0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      equ_d    = (a_in == b_in);
      case (op)
         ADD: begin
            res_d   = add_sum[WIDTH-1:0];
            carry_d = add_sum[WIDTH];
            ovf_d   = (a_in[WIDTH-1] & b_in[WIDTH-1] & ~add_sum[WIDTH-1]) |
                      (~a_in[WIDTH-1] & ~b_in[WIDTH-1] & add_sum[WIDTH-1]);
         end
         SUB: begin
            res_d   = sub_diff[WIDTH-1:0];
            carry_d = sub_diff[WIDTH];
            ovf_d   = (a_in[WIDTH-1] & ~b_in[WIDTH-1] & ~sub_diff[WIDTH-1]) |
                      (~a_in[WIDTH-1] & b_in[WIDTH-1] & sub_diff[WIDTH-1]);
         end
         ROT_L, ROT_R: res_d = rot_value;
         XOR:          res_d = a_in ^ b_in;
         AND:          res_d = a_in & b_in;
         OR:           res_d = a_in | b_in;
         NOT:          res_d = ~a_in;
         default:      res_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         equ_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         res_q   <= res_d;
         carry_q <= carry_d;
         equ_q   <= equ_d;
         ovf_q   <= ovf_d;
      end
   end

   assign a_out        = res_q;
   assign carry_out    = carry_q;
   assign equ_out      = equ_q;
   assign overflow_out = ovf_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_d, zero_q;

   always_comb begin
      zero_d = (res_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) zero_q <= 1'b0;
      else        zero_q <= zero_d;
   end

   assign zero_out = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors, then randomized back-to-back ops.
// Build with ALU_ZERO_FLAG_EN to also check zero_out.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [11:0] a_in;
   logic [11:0] b_in;
   logic        carry_in;
   logic [2:0]  func_code;
   logic [11:0] a_out;
   logic        carry_out;
   logic        equ_out;
   logic        overflow_out;
`ifdef ALU_ZERO_FLAG_EN
   logic        zero_out;
`endif

   alu #(
      .WIDTH (12)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_in         (a_in),
      .b_in         (b_in),
      .carry_in     (carry_in),
      .func_code    (func_code),
      .a_out        (a_out),
      .carry_out    (carry_out),
      .equ_out      (equ_out),
      .overflow_out (overflow_out)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .zero_out     (zero_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] res;
      logic        c;
      logic        e;
      logic        v;
      logic        z;
   } exp_t;

   int   n_vectors = 0;
   int   n_checks  = 0;
   int   n_miscmp  = 0;
   bit   pending   = 0;
   exp_t expd;
   string cur_tag;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on signed/unsigned interpretations.
   function automatic exp_t ref_model(input int unsigned op, input int unsigned a,
                                      input int unsigned b, input int unsigned cin,
                                      input bit rst_low);
      exp_t e;
      int   sa, sb, t, sig;
      int unsigned r;
      e.res = '0; e.c = 0; e.e = 0; e.v = 0; e.z = 0;
      if (rst_low) return e;
      sa = (a >= 2048) ? int'(a) - 4096 : int'(a);
      sb = (b >= 2048) ? int'(b) - 4096 : int'(b);
      r  = (b % 16) % 12;
      case (op)
         0: begin
            t     = int'(a + b + cin);
            e.res = 12'(t % 4096);
            e.c   = (t > 4095);
            sig   = sa + sb + int'(cin);
            e.v   = (sig > 2047) || (sig < -2048);
         end
         1: begin
            t     = int'(a) - int'(b) - int'(cin);
            e.res = 12'((t + 8192) % 4096);
            e.c   = (t < 0);
            sig   = sa - sb - int'(cin);
            e.v   = (sig > 2047) || (sig < -2048);
         end
         2: e.res = 12'(((a << r) | (a >> (12 - r))) % 4096);
         3: e.res = 12'(((a >> r) | (a << (12 - r))) % 4096);
         4: e.res = 12'(a ^ b);
         5: e.res = 12'(a & b);
         6: e.res = 12'(a | b);
         default: e.res = 12'(4095 - a);
      endcase
      e.e = (a == b);
      e.z = (e.res == 12'h000);
      return e;
   endfunction

   task automatic check_pending();
      if (pending) begin
         check({cur_tag, ".a_out"}, 32'(a_out), 32'(expd.res));
         check({cur_tag, ".carry"}, 32'(carry_out), 32'(expd.c));
         check({cur_tag, ".equ"}, 32'(equ_out), 32'(expd.e));
         check({cur_tag, ".ovf"}, 32'(overflow_out), 32'(expd.v));
`ifdef ALU_ZERO_FLAG_EN
         check({cur_tag, ".zero"}, 32'(zero_out), 32'(expd.z));
`endif
      end
   endtask

   // At each falling edge: check the previous vector's result, then drive the next one.
   task automatic apply(input string tag, input logic [2:0] op, input logic [11:0] a,
                        input logic [11:0] b, input logic cin, input logic rst_val);
      @(negedge clk);
      check_pending();
      rst_n     = rst_val;
      func_code = op;
      a_in      = a;
      b_in      = b;
      carry_in  = cin;
      expd      = ref_model(int'(op), int'(a), int'(b), int'(cin), !rst_val);
      cur_tag   = tag;
      pending   = 1;
      n_vectors++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  rop;
      logic [11:0] ra, rb;
      rst_n = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0; func_code = 3'b000;
      repeat (2) @(negedge clk);

      apply("rst_init", 3'b000, 12'h123, 12'h123, 1'b1, 1'b0);
      apply("add_fff_1", 3'b000, 12'hFFF, 12'h001, 1'b0, 1'b1);
      apply("rst_hold", 3'b000, 12'hFFF, 12'h001, 1'b0, 1'b0);
      apply("add_7ff_1", 3'b000, 12'h7FF, 12'h001, 1'b0, 1'b1);
      apply("add_800_fff_c", 3'b000, 12'h800, 12'hFFF, 1'b1, 1'b1);
      apply("sub_800_fff_b", 3'b001, 12'h800, 12'hFFF, 1'b1, 1'b1);
      apply("sub_0_0", 3'b001, 12'h000, 12'h000, 1'b0, 1'b1);
      apply("sub_7ff_800", 3'b001, 12'h7FF, 12'h800, 1'b0, 1'b1);
      apply("rotl_c00_1", 3'b010, 12'hC00, 12'h001, 1'b1, 1'b1);
      apply("rotr_001_1", 3'b011, 12'h001, 12'h001, 1'b0, 1'b1);
      apply("rotl_fff_4", 3'b010, 12'hFFF, 12'h004, 1'b0, 1'b1);
      apply("rotr_123_12", 3'b011, 12'h123, 12'hF0C, 1'b1, 1'b1);
      apply("rotl_001_13", 3'b010, 12'h001, 12'h00D, 1'b0, 1'b1);
      apply("rotr_abc_15", 3'b011, 12'hABC, 12'h00F, 1'b0, 1'b1);
      apply("xor_aaa_555", 3'b100, 12'hAAA, 12'h555, 1'b1, 1'b1);
      apply("and_fff_555", 3'b101, 12'hFFF, 12'h555, 1'b0, 1'b1);
      apply("or_000_555", 3'b110, 12'h000, 12'h555, 1'b1, 1'b1);
      apply("not_000", 3'b111, 12'h000, 12'h000, 1'b1, 1'b1);
      apply("not_fff", 3'b111, 12'hFFF, 12'h123, 1'b0, 1'b1);

      for (int i = 0; i < 160; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 12'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? ra : 12'($urandom);
         apply($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom),
               ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
      end

      @(negedge clk);
      check_pending();
      pending = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscmp);
      $finish;
   end

endmodule
